// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the round-robin register-bus arbiter.
package reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultTimeoutCycles = 255;

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Rotating priority encoder: returns the first set valid bit at or after i_ptr,
// wrapping modulo NumReq.
module reg_arb_rr_pick #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] i_valid,
    input  logic [IdxW-1:0]   i_ptr,
    output logic [IdxW-1:0]   o_idx,
    output logic              o_any
);

    logic [IdxW:0]   w_sum;
    logic [IdxW-1:0] w_pos;

    // Walk from farthest to nearest so the candidate closest to i_ptr wins.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_ptr} + (IdxW + 1)'(i);
            if (w_sum >= (IdxW + 1)'(NumReq)) begin
                w_sum = w_sum - (IdxW + 1)'(NumReq);
            end
            w_pos = w_sum[IdxW-1:0];
            if (i_valid[w_pos]) begin
                o_idx = w_pos;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream register bus among NumReq requesters,
// with grant locking for the whole transfer and a watchdog that forces an error response.
module reg_bus_rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NumReq        = 4,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int StrbWidth     = DataWidth / 8,
    parameter int TimeoutCycles = int'(DefaultTimeoutCycles)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    input  logic [NumReq-1:0]                   req_write_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
    input  logic [NumReq-1:0][StrbWidth-1:0]    req_wstrb_i,
    output logic [NumReq-1:0]                   req_ready_o,
    output logic [DataWidth-1:0]                req_rdata_o,
    output logic                                req_error_o,
    output logic                                bus_valid_o,
    output logic                                bus_write_o,
    output logic [AddrWidth-1:0]                bus_addr_o,
    output logic [DataWidth-1:0]                bus_wdata_o,
    output logic [StrbWidth-1:0]                bus_wstrb_o,
    input  logic                                bus_ready_i,
    input  logic [DataWidth-1:0]                bus_rdata_i,
    input  logic                                bus_error_i,
    output logic                                timeout_o
);

    localparam int IdxW  = $clog2(NumReq);
    localparam int WdogW = $clog2(TimeoutCycles + 1);
    localparam logic [WdogW-1:0] WdogMax = WdogW'(TimeoutCycles);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [IdxW-1:0]  r_sel;
    logic [IdxW-1:0]  r_rr_ptr;
    logic [IdxW-1:0]  w_ptr_next;
    logic [IdxW-1:0]  w_pick_idx;
    logic             w_pick_any;
    logic [WdogW-1:0] r_wdog;
    logic             w_sel_valid;
    logic             w_abort;
    logic             w_done_ok;
    logic             w_done_to;
    logic             w_grant_end;

    reg_arb_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .i_valid (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // A requester that drops valid mid-transfer loses its response even if ready
    // arrives in the same cycle; ready otherwise beats the watchdog.
    assign w_sel_valid = req_valid_i[r_sel];
    assign w_abort     = (r_state == GRANT) && !w_sel_valid;
    assign w_done_ok   = (r_state == GRANT) && w_sel_valid && bus_ready_i;
    assign w_done_to   = (r_state == GRANT) && w_sel_valid && !bus_ready_i && (r_wdog == WdogMax);
    assign w_grant_end = w_abort || w_done_ok || w_done_to;
    assign w_ptr_next  = (r_sel == IdxW'(NumReq - 1)) ? '0 : r_sel + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_wdog   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE) begin
                if (w_pick_any) begin
                    r_sel  <= w_pick_idx;
                    r_wdog <= '0;
                end
            end else if (w_grant_end) begin
                r_rr_ptr <= w_ptr_next;
            end else if (r_wdog != WdogMax) begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_any)  w_state_next = GRANT;
            GRANT:   if (w_grant_end) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        req_rdata_o = '0;
        req_error_o = 1'b0;
        timeout_o   = 1'b0;
        bus_valid_o = 1'b0;
        bus_write_o = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        bus_wstrb_o = '0;
        if (r_state == GRANT) begin
            bus_valid_o = w_sel_valid && !w_done_to;
            bus_write_o = req_write_i[r_sel];
            bus_addr_o  = req_addr_i[r_sel];
            bus_wdata_o = req_wdata_i[r_sel];
            bus_wstrb_o = req_wstrb_i[r_sel];
            if (w_done_ok) begin
                req_ready_o[r_sel] = 1'b1;
                req_rdata_o        = bus_rdata_i;
                req_error_o        = bus_error_i;
            end else if (w_done_to) begin
                req_ready_o[r_sel] = 1'b1;
                req_error_o        = 1'b1;
                timeout_o          = 1'b1;
            end
        end
    end

endmodule
